axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the core's single AXI4 read channel (AR/R) between NUM_REQ cache-refill requesters (req 0 = icache, req 1 = dcache).
//  Round-robin grant; exactly one outstanding burst; grant locked until RLAST.
//  Sits between the cache refill FSMs and the top-level AXI master port.
// PARAMETERS
//  NUM_REQ   2   number of requesters (>=2)
//  ADDR_W    32  address width
//  DATA_W    32  AXI data width
//  ID_W      4   ARID/RID width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk            in   1                 core clock
//  rst_n          in   1                 async active-low reset
//  req_valid      in   NUM_REQ           requester has a burst request
//  req_ready      out  NUM_REQ           request accepted (one-hot or zero)
//  req_addr       in   NUM_REQ x ADDR_W  burst start address
//  req_len        in   NUM_REQ x 8       AXI ARLEN (beats-1)
//  req_size       in   NUM_REQ x 3       AXI ARSIZE
//  resp_valid     out  NUM_REQ           beat valid, only to current owner
//  resp_ready     in   NUM_REQ           owner accepts beat
//  resp_data      out  DATA_W            beat data (shared bus)
//  resp_last      out  1                 last beat of burst
//  resp_err       out  1                 RRESP != OKAY on this beat
//  arid/araddr/arlen/arsize/arburst  out  ID_W/ADDR_W/8/3/2  AXI AR fields
//  arvalid out 1; arready in 1
//  rid in ID_W; rdata in DATA_W; rresp in 2; rlast in 1; rvalid in 1; rready out 1
// BEHAVIOUR
//  Clock clk; reset asynchronous, active-low on rst_n.
//  Reset: state=IDLE, arvalid=0, rready=0, req_ready=0, resp_valid=0, rr_ptr=0 (req 0 highest priority).
//  FSM states IDLE -> AR -> R -> IDLE.
//  IDLE: winner = first req_valid at or after rr_ptr (wrapping mod NUM_REQ).
//   - req_ready[winner]=1 combinationally, all other bits 0.
//   - On handshake: latch addr/len/size; owner=winner; go AR. No valid request -> stay.
//  AR: arvalid=1 from registers (first possible the cycle after accept); arid=owner, arburst=INCR(2'b01).
//   - AR fields stable while arvalid && !arready; arready -> R.
//  R: rready=resp_ready[owner]; resp_valid[owner]=rvalid; others 0.
//   - resp_data=rdata; resp_last=rlast; resp_err=(rresp!=0). Combinational pass-through, zero added latency.
//   - rvalid&&rready&&rlast -> IDLE, rr_ptr=(owner+1) mod NUM_REQ; new request acceptable the next cycle.
//  Min. request-to-AR latency: 1 cycle. No new AR before previous RLAST; req_ready=0 in AR/R.
//  rid!=owner: simulation assertion only; beat still delivered to owner.
//  Error beats do not abort the burst; the arbiter waits for rlast regardless.
//  Requester dropping req_valid in IDLE before handshake: legal, no effect.
//  Only valid/ready stall the burst; owner may hold resp_ready=0 arbitrarily.
//  No flush input: in-flight bursts always drain; requesters discard stale data.
//  Reset mid-burst: FSM returns to IDLE immediately; AXI-side recovery is a system reset concern.
// STRUCTURE
//  AXI constants (BURST_INCR, RESP_OKAY) and axi_ar_t/axi_r_t structs go in a_defines.svh.
//  Sub-module rr_picker: combinational round-robin one-hot select (req vec, ptr -> grant onehot + index).
//  FSM, AR register set and R mux stay in axi_rd_arbiter.
// TESTING
//  1. After reset: only req1 valid, addr=0x1C000040 len=3.
//     -> req_ready[1] same cycle; arvalid next cycle, arid=1, araddr=0x1C000040, arlen=3, arburst=1.
//  2. Both req valid, rr_ptr=0 -> req0 granted; after its rlast both still valid -> req1 granted next (fair alternation over 4 bursts).
//  3. Hold arready=0 for 5 cycles -> AR fields stable, req_ready=0 throughout.
//  4. During R, owner resp_ready toggles 1,0,1,0 over 4 beats -> rready tracks it.
//     -> Exactly 4 beats delivered, no loss or duplication; non-owner resp_valid stays 0.
//  5. Beat 2 of 4 rresp=2'b10 -> resp_err=1 on that beat only; burst completes; FSM returns to IDLE after rlast.
//  6. Assert rst_n=0 mid-R -> arvalid=rready=0, state IDLE, rr_ptr=0 asynchronously.
//     -> After release, fresh req0 is accepted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the cache-refill read arbiter.
// Imported by the arbiter top and its round-robin picker.
package axi_rd_arbiter_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    // Index of the requester after idx, wrapping at n.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping modulo NUM_REQ, returned as a one-hot grant plus its index.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant[IDX_W'(cand)] = 1'b1;
                grant_idx           = IDX_W'(cand);
                grant_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between NUM_REQ cache-refill requesters:
// round-robin grant, one outstanding burst, grant held until RLAST.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][7:0]          req_len,
    input  logic [NUM_REQ-1:0][2:0]          req_size,
    output logic [NUM_REQ-1:0]               resp_valid,
    input  logic [NUM_REQ-1:0]               resp_ready,
    output logic [DATA_W-1:0]                resp_data,
    output logic                             resp_last,
    output logic                             resp_err,
    output logic [ID_W-1:0]                  arid,
    output logic [ADDR_W-1:0]                araddr,
    output logic [7:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [ID_W-1:0]                  rid,
    input  logic [DATA_W-1:0]                rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [2:0]         size_q, size_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        req_ready  = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = '0;

        unique case (state_q)
            ST_IDLE: begin
                // The picker only grants a requester that is valid, so a grant is a handshake.
                req_ready = pick_grant;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    addr_d  = req_addr[pick_idx];
                    len_d   = req_len[pick_idx];
                    size_d  = req_size[pick_idx];
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready              = resp_ready[owner_q];
                resp_valid[owner_q] = rvalid;
                if (rvalid && resp_ready[owner_q] && rlast) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = IDX_W'(next_ptr(32'(owner_q), NUM_REQ));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
        end
    end

    assign arid    = ID_W'(owner_q);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = BURST_INCR;

    // Beat fields pass straight through; only the valid/ready pair is steered to the owner.
    assign resp_data = rdata;
    assign resp_last = rlast;
    assign resp_err  = (rresp != RESP_OKAY);

    rid_matches_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_R && rvalid) |-> (rid == ID_W'(owner_q)));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter: request-level arbitration model, AXI slave
// responder, and a scoreboard monitor that checks every AR and R handshake.
module tb_axi_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM_REQ-1:0]             req_valid, req_ready, resp_valid, resp_ready;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][7:0]        req_len;
    logic [NUM_REQ-1:0][2:0]        req_size;
    logic [DATA_W-1:0]              resp_data;
    logic                           resp_last, resp_err;
    logic [ID_W-1:0]                arid;
    logic [ADDR_W-1:0]              araddr;
    logic [7:0]                     arlen;
    logic [2:0]                     arsize;
    logic [1:0]                     arburst;
    logic                           arvalid, arready;
    logic [ID_W-1:0]                rid;
    logic [DATA_W-1:0]              rdata;
    logic [1:0]                     rresp;
    logic                           rlast, rvalid, rready;

    axi_rd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_err   (resp_err),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
    } ar_t;

    typedef struct {
        int                owner;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              err;
    } beat_t;

    typedef enum {M_IDLE, M_AR, M_R} mstate_e;

    int n_vec = 0;
    int n_err = 0;
    int n_bursts = 0;
    int mon_beats = 0;

    ar_t   ar_q[$];
    beat_t beat_q[$];
    int    dut_grants[$];

    // Reference model: who owns the channel and whose turn it is.
    mstate_e m_state = M_IDLE;
    int      m_ptr = 0;
    int      m_owner = 0;
    ar_t     m_ar;

    // Requesters.
    logic [NUM_REQ-1:0] pend = '0;
    logic [ADDR_W-1:0]  p_addr [NUM_REQ];
    logic [7:0]         p_len  [NUM_REQ];
    logic [2:0]         p_size [NUM_REQ];

    // Stimulus knobs.
    logic [NUM_REQ-1:0] auto_en = '0;
    int   auto_pct = 0;
    bit   hold_valid = 1'b1;
    int   ar_stall = 0;
    bit   rr_toggle = 1'b0;
    bit   tog = 1'b1;
    bit   rvalid_always = 1'b0;
    int   err_beat = -1;
    int   err_pct = 0;
    int   fix_len = -1;

    // AXI slave responder.
    bit                s_busy = 1'b0;
    bit                s_hold = 1'b0;
    int                s_left = 0;
    int                s_idx = 0;
    logic [ID_W-1:0]   s_id = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic [1:0]        s_resp = '0;
    logic              s_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic inject(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l,
                          input logic [2:0] s);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_len[i]  = l;
        p_size[i] = s;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_rr;
        logic [NUM_REQ-1:0] exp_rv;
        logic               exp_rrdy;
        int                 win;
        int                 c;
        ar_t                w_ar;

        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && auto_en[i] && ($urandom_range(99, 0) < auto_pct))
                inject(i, $urandom & 32'hFFFF_FFC0,
                       (fix_len >= 0) ? 8'(fix_len) : 8'($urandom_range(7, 0)), 3'd2);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = pend[i] && (hold_valid || ($urandom_range(3, 0) != 0));
            req_addr[i]  = p_addr[i];
            req_len[i]   = p_len[i];
            req_size[i]  = p_size[i];
        end
        if (rr_toggle) begin
            resp_ready = tog ? '1 : '0;
            tog = !tog;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) resp_ready[i] = ($urandom_range(2, 0) != 0);
        end
        if (m_state == M_AR && ar_stall > 0) begin
            arready = 1'b0;
            ar_stall--;
        end else begin
            arready = 1'($urandom_range(1, 0));
        end
        if (s_busy && !s_hold && (rvalid_always || $urandom_range(2, 0) != 0)) begin
            s_hold = 1'b1;
            s_data = $urandom;
            s_resp = (s_idx == err_beat || $urandom_range(99, 0) < err_pct) ? 2'b10 : 2'b00;
            s_last = (s_left == 1);
        end
        rvalid = s_hold;
        rdata  = s_data;
        rresp  = s_resp;
        rlast  = s_hold && s_last;
        rid    = s_id;

        win = -1;
        exp_rr = '0;
        exp_rv = '0;
        exp_rrdy = 1'b0;
        if (m_state == M_IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (m_ptr + k) % NUM_REQ;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        if (win >= 0) begin
            exp_rr[win] = 1'b1;
            w_ar.id   = ID_W'(win);
            w_ar.addr = p_addr[win];
            w_ar.len  = p_len[win];
            w_ar.size = p_size[win];
            ar_q.push_back(w_ar);
            pend[win] = 1'b0;
        end
        if (m_state == M_R) begin
            exp_rrdy = resp_ready[m_owner];
            exp_rv[m_owner] = rvalid;
            if (rvalid && resp_ready[m_owner])
                beat_q.push_back('{owner: m_owner, data: rdata, last: rlast, err: (rresp != 2'b00)});
        end

        @(negedge clk);
        check("req_ready", req_ready, exp_rr);
        check("arvalid", arvalid, (m_state == M_AR));
        check("rready", rready, exp_rrdy);
        check("resp_valid", resp_valid, exp_rv);
        if (m_state == M_AR)
            check("ar_fields_stable", {arid, araddr, arlen, arsize, arburst},
                  {m_ar.id, m_ar.addr, m_ar.len, m_ar.size, 2'b01});
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) dut_grants.push_back(k);

        case (m_state)
            M_IDLE: if (win >= 0) begin
                m_state = M_AR;
                m_owner = win;
                m_ar    = w_ar;
            end
            M_AR: if (arready) m_state = M_R;
            M_R: if (rvalid && resp_ready[m_owner] && rlast) begin
                m_state = M_IDLE;
                m_ptr   = (m_owner + 1) % NUM_REQ;
                n_bursts++;
            end
            default: m_state = M_IDLE;
        endcase

        if (arvalid && arready) begin
            s_busy = 1'b1;
            s_left = int'(arlen) + 1;
            s_id   = arid;
            s_idx  = 0;
        end
        if (rvalid && rready) begin
            s_hold = 1'b0;
            s_left--;
            s_idx++;
            if (s_last) s_busy = 1'b0;
        end
    endtask

    task automatic run_bursts(input int n, input int budget, input string tag);
        int target;
        int cyc;
        target = n_bursts + n;
        cyc = 0;
        while (n_bursts < target && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_bursts_done"}, (n_bursts >= target), 1'b1);
    endtask

    task automatic run_quiet(input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (!(m_state == M_IDLE && pend == '0) && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_quiet"}, (m_state == M_IDLE && pend == '0), 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid && arready) begin
                ar_t e;
                check("ar_expected_pending", (ar_q.size() != 0), 1'b1);
                if (ar_q.size() != 0) begin
                    e = ar_q.pop_front();
                    check("ar_handshake", {arid, araddr, arlen, arsize, arburst},
                          {e.id, e.addr, e.len, e.size, 2'b01});
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (resp_valid[k] && resp_ready[k]) begin
                    beat_t b;
                    mon_beats++;
                    check("beat_expected_pending", (beat_q.size() != 0), 1'b1);
                    if (beat_q.size() != 0) begin
                        b = beat_q.pop_front();
                        check("beat_owner", k, b.owner);
                        check("beat_payload", {resp_data, resp_last, resp_err},
                              {b.data, b.last, b.err});
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int b0;
        req_valid = '0;
        req_addr = '0;
        req_len = '0;
        req_size = '0;
        resp_ready = '0;
        arready = 1'b0;
        rid = '0;
        rdata = '0;
        rresp = '0;
        rlast = 1'b0;
        rvalid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            p_addr[i] = '0;
            p_len[i]  = '0;
            p_size[i] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_req_ready", req_ready, '0);
        check("rst_resp_valid", resp_valid, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from the dcache right after reset.
        inject(1, 32'h1C00_0040, 8'd3, 3'd2);
        step();
        check("t1_req_ready", req_ready, 2'b10);
        step();
        check("t1_arvalid", arvalid, 1'b1);
        check("t1_arid", arid, 4'd1);
        check("t1_araddr", araddr, 32'h1C00_0040);
        check("t1_arlen", arlen, 8'd3);
        check("t1_arburst", arburst, 2'b01);
        run_bursts(1, 200, "t1");

        // Both requesters continuously valid: grants must alternate.
        dut_grants.delete();
        auto_en = '1;
        auto_pct = 100;
        fix_len = 1;
        run_bursts(4, 400, "t2");
        check("t2_grant_count", (dut_grants.size() >= 4), 1'b1);
        if (dut_grants.size() >= 4) begin
            check("t2_grant0", dut_grants[0], 0);
            check("t2_grant1", dut_grants[1], 1);
            check("t2_grant2", dut_grants[2], 0);
            check("t2_grant3", dut_grants[3], 1);
        end
        auto_en = '0;
        run_quiet(400, "t2");

        // Address channel stalled for 5 cycles with another requester waiting.
        inject(0, 32'h0000_1200, 8'd2, 3'd2);
        inject(1, 32'h0000_3400, 8'd1, 3'd2);
        ar_stall = 5;
        run_bursts(2, 400, "t3");

        // Owner toggles resp_ready each cycle over a 4-beat burst.
        rr_toggle = 1'b1;
        tog = 1'b1;
        rvalid_always = 1'b1;
        b0 = mon_beats;
        inject(0, 32'h0000_5600, 8'd3, 3'd2);
        run_bursts(1, 200, "t4");
        check("t4_beats", mon_beats - b0, 4);
        rr_toggle = 1'b0;

        // Error response on beat 2 of 4.
        err_beat = 1;
        b0 = mon_beats;
        inject(1, 32'h0000_7800, 8'd3, 3'd2);
        run_bursts(1, 200, "t5");
        check("t5_beats", mon_beats - b0, 4);
        err_beat = -1;
        rvalid_always = 1'b0;
        step();
        check("t5_back_idle_arvalid", arvalid, 1'b0);

        // Randomised traffic.
        auto_en = '1;
        auto_pct = 30;
        hold_valid = 1'b0;
        err_pct = 10;
        fix_len = -1;
        repeat (600) step();
        auto_en = '0;
        hold_valid = 1'b1;
        run_quiet(2000, "rand");

        // Reset in the middle of a read burst.
        inject(0, 32'h0000_9A00, 8'd7, 3'd2);
        b0 = 0;
        while (m_state != M_R && b0 < 200) begin
            step();
            b0++;
        end
        check("t6_reached_r", (m_state == M_R), 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req_valid = '0;
        rvalid = 1'b0;
        rlast = 1'b0;
        arready = 1'b0;
        #1;
        check("t6_arvalid", arvalid, 1'b0);
        check("t6_rready", rready, 1'b0);
        check("t6_resp_valid", resp_valid, '0);
        check("t6_req_ready", req_ready, '0);
        m_state = M_IDLE;
        m_ptr = 0;
        pend = '0;
        s_busy = 1'b0;
        s_hold = 1'b0;
        ar_q.delete();
        beat_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh requests after reset: req0 has priority again.
        dut_grants.delete();
        inject(1, 32'h0000_BC00, 8'd1, 3'd2);
        inject(0, 32'h0000_DE00, 8'd2, 3'd2);
        run_bursts(2, 400, "t6");
        check("t6_first_grant_present", (dut_grants.size() >= 1), 1'b1);
        if (dut_grants.size() >= 1) check("t6_first_grant", dut_grants[0], 0);

        run_quiet(400, "end");
        repeat (2) step();
        check("end_ar_q_empty", ar_q.size(), 0);
        check("end_beat_q_empty", beat_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
